alif_param_loader: RTL and testbench
====================================

# alif_param_loader

Serial configuration controller for the ALIF neuron datapath. Deserialises parameter frames arriving on the `load_mode` / `serial_data` pins and validates them. Commits each frame atomically to the neuron's active parameter registers, but only while the neuron is not mid-update. Sits between the top-level pin mapping and the neuron core, and owns `params_ready`.

## Interface
Parameters:
- `DEF_THRESH`, default 8'd64: threshold after reset.
- `DEF_LEAK`, default 4'd2: leak shift after reset.
- `DEF_ADAPT_INC`, default 4'd1: adaptation increment after reset.
- `DEF_ADAPT_DEC`, default 4'd1: adaptation decay after reset.
- `DEF_REFRAC`, default 4'd3: refractory cycles after reset.

Ports:
- `clk`  in  1  single clock. **Already decided.**
- `rst_n`  in  1  reset, asynchronous, active-low. **Already decided.**
- `load_mode`  in  1  raw pin; high frames a configuration transfer.
- `serial_data`  in  1  raw pin; one bit per `clk`, MSB first.
- `commit_hold`  in  1  neuron mid-update; defers commit while high.
- `threshold`  out  8  active threshold.
- `leak_shift`  out  4  active leak.
- `adapt_inc`  out  4  active adaptation increment.
- `adapt_dec`  out  4  active adaptation decay.
- `refrac_len`  out  4  active refractory length.
- `params_ready`  out  1  active set valid and no load in progress.
- `cfg_update`  out  1  one-cycle pulse on commit.
- `cfg_error`  out  1  sticky error; cleared by the next accepted commit.

## Operation
- Input synchronisation:
  - `load_mode` and `serial_data` pass through identical 2-flop synchronisers (`lm_s`, `sd_s`), so the pair stays aligned.
  - All logic below uses the synchronised values.
- Frame layout, MSB first:
  - threshold[7:0], leak[3:0], adapt_inc[3:0], adapt_dec[3:0], refrac[3:0]: 24 bits.
  - Followed by an optional checksum nibble (see Configuration).
- The payload shifts into a shadow register. Active outputs change only on commit.
- States:
  - IDLE:
    - `lm_s`=1 → SHIFT.
    - That same cycle's `sd_s` is bit 0 of the frame; the bit counter is loaded with 1.
    - `params_ready` drops.
  - SHIFT:
    - Shift `sd_s` each cycle `lm_s`=1, counter +1.
    - Counter reaches FRAME_BITS → CHECK.
    - `lm_s` falls early → short frame: set `cfg_error`, restore `params_ready` to its pre-load value, → IDLE.
  - CHECK (1 cycle):
    - Checksum fails → set `cfg_error`, restore `params_ready`, → DRAIN.
    - Otherwise → PEND.
  - PEND:
    - Wait while `commit_hold`=1.
    - When `commit_hold`=0: copy shadow to the active outputs, pulse `cfg_update`, clear `cfg_error`, set `params_ready`, → DRAIN.
  - DRAIN: ignore `sd_s`; `lm_s`=0 → IDLE.
- Extra bits beyond FRAME_BITS within one `load_mode` window are discarded.
- A new frame requires `load_mode` to go low and then high again.
- `load_mode` dropping during PEND does not abort the commit.

## Timing
- Reset values:
  - Active registers = DEF_* parameters.
  - `params_ready`=0, `cfg_update`=0, `cfg_error`=0.
  - FSM = IDLE, shadow = 0, counter = 0.
- Pin-to-FSM latency: 2 cycles.
- Commit latency:
  - Last frame bit is sampled in SHIFT at cycle N.
  - CHECK runs at N+1.
  - Earliest commit edge is N+2 with `commit_hold`=0: outputs and `cfg_update` are valid in cycle N+2.
- `commit_hold`=1 adds exactly one cycle per held cycle. No timeout.
- `rst_n` asserted mid-frame or in PEND:
  - Immediate return to reset values.
  - The partial frame is lost and nothing is committed.
- `cfg_error` and `cfg_update` are never both asserted in the same cycle.

## Configuration
- Macro: `ALIF_CFG_CHECKSUM_EN`.
- Defined:
  - FRAME_BITS = 28.
  - Trailing nibble must equal the XOR of the six payload nibbles; a mismatch is an error.
- Undefined:
  - FRAME_BITS = 24.
  - CHECK always passes; the checksum logic is absent.
  - `cfg_error` only flags short frames.

## Structure
- Shared package `alif_cfg_pkg` holds:
  - Field widths and FRAME_BITS.
  - The FSM state enum (IDLE, SHIFT, CHECK, PEND, DRAIN).
  - The packed parameter-set typedef shared with the neuron core.
- One sub-module: `alif_cfg_sync`, the 2-flop synchroniser, instantiated twice.

## Test plan
- Reset with no frame:
  - Outputs equal 64/2/1/1/3.
  - `params_ready`=0, `cfg_error`=0.
- Valid frame, `commit_hold`=0:
  - Checksum build: payload 24'h403215, frame 28'h4032151.
  - No-checksum build: payload 24'h403215, frame 24'h403215.
  - Outputs become threshold 0x40, leak 3, inc 2, dec 1, refrac 5.
  - `cfg_update` pulses once, 2 cycles after the last synchronised bit.
  - `params_ready`=1.
- Same frame with `commit_hold` high for 5 cycles after CHECK:
  - Commit is delayed exactly 5 cycles.
  - Outputs are stable until then.
- Short frame:
  - `load_mode` dropped after 10 bits.
  - `cfg_error`=1, outputs unchanged, `params_ready` back to its prior value.
- Checksum build, frame 28'h4032150 (bad nibble):
  - `cfg_error`=1, no `cfg_update`.
  - A following good frame commits and clears `cfg_error`.
- `rst_n` pulsed low at frame bit 12:
  - All outputs return to reset values.
  - A subsequent full frame commits normally.

Source files
------------

// File: rtl/alif_cfg_pkg.sv
// alif_cfg_pkg
// Shared definitions for the ALIF configuration loader and the neuron core:
// field widths, serial frame length, loader FSM state encoding and the packed
// parameter-set type.
// Optional feature macro: ALIF_CFG_CHECKSUM_EN (adds a trailing XOR checksum
// nibble to every frame).
package alif_cfg_pkg;

  localparam int THRESH_W     = 8;
  localparam int NIB_W        = 4;
  localparam int PAYLOAD_BITS = THRESH_W + 4 * NIB_W;

`ifdef ALIF_CFG_CHECKSUM_EN
  localparam int FRAME_BITS = PAYLOAD_BITS + NIB_W;
`else
  localparam int FRAME_BITS = PAYLOAD_BITS;
`endif

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    PEND,
    DRAIN
  } cfg_state_t;

  // Field order matches the serial frame order (MSB first).
  typedef struct packed {
    logic [THRESH_W-1:0] threshold;
    logic [NIB_W-1:0]    leak_shift;
    logic [NIB_W-1:0]    adapt_inc;
    logic [NIB_W-1:0]    adapt_dec;
    logic [NIB_W-1:0]    refrac_len;
  } alif_params_t;

`ifdef ALIF_CFG_CHECKSUM_EN
  // XOR of the six payload nibbles.
  function automatic logic [NIB_W-1:0] payload_xor(input logic [PAYLOAD_BITS-1:0] p);
    logic [NIB_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < PAYLOAD_BITS / NIB_W; i++) begin
      acc = acc ^ p[i*NIB_W +: NIB_W];
    end
    return acc;
  endfunction
`endif

endpackage

// File: rtl/alif_cfg_sync.sv
// alif_cfg_sync
// Two-flop synchroniser for one raw pin.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (flops clear to 0)
//   d     - asynchronous input pin
//   q     - synchronised output, two clk cycles behind d
module alif_cfg_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/alif_param_loader.sv
// alif_param_loader
// Serial configuration controller for the ALIF neuron. Deserialises frames
// from load_mode/serial_data into a shadow register, validates them and
// commits them atomically to the active parameter outputs once commit_hold
// is low.
// Optional feature macro: ALIF_CFG_CHECKSUM_EN (28-bit frames with an XOR
// checksum nibble; otherwise 24-bit frames and no checksum check).
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   load_mode             - raw pin, high frames a transfer
//   serial_data           - raw pin, one bit per clk, MSB first
//   commit_hold           - neuron mid-update, defers the commit
//   threshold..refrac_len - active parameter set
//   params_ready          - active set valid and no load in progress
//   cfg_update            - one-cycle pulse on commit
//   cfg_error             - sticky error, cleared by the next commit
//
// state | meaning
// IDLE  | waiting for lm_s to rise; first bit captured on entry to SHIFT
// SHIFT | shifting frame bits; early lm_s fall is a short-frame error
// CHECK | one-cycle checksum validation
// PEND  | frame valid, waiting for commit_hold low
// DRAIN | discarding bits until lm_s falls
module alif_param_loader
  import alif_cfg_pkg::*;
#(
  parameter logic [7:0] DEF_THRESH    = 8'd64,
  parameter logic [3:0] DEF_LEAK      = 4'd2,
  parameter logic [3:0] DEF_ADAPT_INC = 4'd1,
  parameter logic [3:0] DEF_ADAPT_DEC = 4'd1,
  parameter logic [3:0] DEF_REFRAC    = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_mode,
  input  logic       serial_data,
  input  logic       commit_hold,
  output logic [7:0] threshold,
  output logic [3:0] leak_shift,
  output logic [3:0] adapt_inc,
  output logic [3:0] adapt_dec,
  output logic [3:0] refrac_len,
  output logic       params_ready,
  output logic       cfg_update,
  output logic       cfg_error
);

  localparam alif_params_t         DEF_PARAMS = {DEF_THRESH, DEF_LEAK, DEF_ADAPT_INC,
                                                 DEF_ADAPT_DEC, DEF_REFRAC};
  localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(FRAME_BITS - 1);

  logic                  lm_s;
  logic                  sd_s;
  cfg_state_t            state_q;
  logic [FRAME_BITS-1:0] shadow_q;
  logic [CNT_W-1:0]      cnt_q;
  alif_params_t          active_q;
  alif_params_t          shadow_payload;
  logic                  ready_q;
  logic                  ready_pre_q;
  logic                  update_q;
  logic                  error_q;
  logic                  check_ok;

  alif_cfg_sync u_sync_lm (.clk(clk), .rst_n(rst_n), .d(load_mode),   .q(lm_s));
  alif_cfg_sync u_sync_sd (.clk(clk), .rst_n(rst_n), .d(serial_data), .q(sd_s));

  assign shadow_payload = shadow_q[FRAME_BITS-1 -: PAYLOAD_BITS];

`ifdef ALIF_CFG_CHECKSUM_EN
  assign check_ok = (shadow_q[NIB_W-1:0] == payload_xor(shadow_payload));
`else
  assign check_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      active_q    <= DEF_PARAMS;
      ready_q     <= 1'b0;
      ready_pre_q <= 1'b0;
      update_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lm_s) begin
            shadow_q    <= {{(FRAME_BITS-1){1'b0}}, sd_s};
            cnt_q       <= CNT_W'(1);
            ready_pre_q <= ready_q;
            ready_q     <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (lm_s) begin
            shadow_q <= {shadow_q[FRAME_BITS-2:0], sd_s};
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q <= CHECK;
            end
          end else begin
            // short frame: drop it and restore the readiness seen before the load
            error_q <= 1'b1;
            ready_q <= ready_pre_q;
            state_q <= IDLE;
          end
        end
        CHECK: begin
          if (check_ok) begin
            state_q <= PEND;
          end else begin
            error_q <= 1'b1;
            ready_q <= ready_pre_q;
            state_q <= DRAIN;
          end
        end
        PEND: begin
          // commits regardless of lm_s; only commit_hold can defer it
          if (!commit_hold) begin
            active_q <= shadow_payload;
            update_q <= 1'b1;
            error_q  <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!lm_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign threshold    = active_q.threshold;
  assign leak_shift   = active_q.leak_shift;
  assign adapt_inc    = active_q.adapt_inc;
  assign adapt_dec    = active_q.adapt_dec;
  assign refrac_len   = active_q.refrac_len;
  assign params_ready = ready_q;
  assign cfg_update   = update_q;
  assign cfg_error    = error_q;

endmodule

// File: tb/tb_alif_param_loader.sv
// tb_alif_param_loader
// Self-checking bench for alif_param_loader. Frames are driven on the raw
// pins; a frame-level model (payload, ready, error) predicts the outcome.
// Honours ALIF_CFG_CHECKSUM_EN to build matching frames.
module tb_alif_param_loader;

`ifdef ALIF_CFG_CHECKSUM_EN
  localparam int FB = 28;
`else
  localparam int FB = 24;
`endif
  localparam logic [23:0] DEF_PAR = {8'd64, 4'd2, 4'd1, 4'd1, 4'd3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_mode = 1'b0;
  logic       serial_data = 1'b0;
  logic       commit_hold = 1'b0;
  logic [7:0] threshold;
  logic [3:0] leak_shift, adapt_inc, adapt_dec, refrac_len;
  logic       params_ready, cfg_update, cfg_error;
  logic [23:0] outs;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // frame-level reference state
  logic [23:0] m_par;
  logic        m_ready, m_err;

  // observations from the last frame
  int c_last, n_upd, upd_at, both_hi, chg_early;
  logic [23:0] pre_par;

  alif_param_loader dut (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .serial_data(serial_data),
    .commit_hold(commit_hold), .threshold(threshold), .leak_shift(leak_shift),
    .adapt_inc(adapt_inc), .adapt_dec(adapt_dec), .refrac_len(refrac_len),
    .params_ready(params_ready), .cfg_update(cfg_update), .cfg_error(cfg_error)
  );

  assign outs = {threshold, leak_shift, adapt_inc, adapt_dec, refrac_len};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] nib_xor(input logic [23:0] p);
    return p[23:20] ^ p[19:16] ^ p[15:12] ^ p[11:8] ^ p[7:4] ^ p[3:0];
  endfunction

  function automatic logic [31:0] mk_frame(input logic [23:0] p);
`ifdef ALIF_CFG_CHECKSUM_EN
    return {4'd0, p, nib_xor(p)};
`else
    return {8'd0, p};
`endif
  endfunction

  // Drive nbits of 'bits' (MSB first), then observe a fixed window. With
  // hold>0, commit_hold stays high for 'hold' cycles after CHECK.
  task automatic send(input logic [31:0] bits, input int nbits, input int hold);
    pre_par = outs;
    commit_hold = (hold > 0);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      load_mode = 1'b1;
      serial_data = bits[i];
      c_last = cyc;
    end
    n_upd = 0; upd_at = -1; both_hi = 0; chg_early = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin load_mode = 1'b0; serial_data = 1'b0; end
      if (hold > 0 && cyc == c_last + 4 + hold) commit_hold = 1'b0;
      @(negedge clk);
      if (cfg_update) begin n_upd++; if (upd_at < 0) upd_at = cyc; end
      if (cfg_update && cfg_error) both_hi++;
      if (!cfg_update && n_upd == 0 && outs !== pre_par) chg_early++;
    end
    commit_hold = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_par = DEF_PAR; m_ready = 1'b0; m_err = 1'b0;
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL reset_params: got %h want %h", outs, m_par); end
    n_chk++; if (params_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", params_ready); end
    n_chk++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", cfg_error); end
    n_chk++; if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b want 0", cfg_update); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_chk++; if (outs !== m_par || params_ready !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h/%b want %h/0", outs, params_ready, m_par);
    end
  endtask

  task automatic test_valid_frame();
    send(mk_frame(24'h403215), FB, 0);
    m_par = 24'h403215; m_ready = 1'b1; m_err = 1'b0;
    n_chk++; if (n_upd !== 1) begin n_fail++; $display("FAIL valid_update_count: got %0d want 1", n_upd); end
    n_chk++; if (upd_at !== c_last + 5) begin n_fail++; $display("FAIL valid_latency: got %0d want %0d", upd_at, c_last + 5); end
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL valid_params: got %h want %h", outs, m_par); end
    n_chk++; if (params_ready !== 1'b1) begin n_fail++; $display("FAIL valid_ready: got %b want 1", params_ready); end
    n_chk++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL valid_error: got %b want 0", cfg_error); end
  endtask

  task automatic test_commit_hold();
    logic [23:0] p;
    p = 24'($urandom);
    send(mk_frame(p), FB, 5);
    m_par = p; m_ready = 1'b1; m_err = 1'b0;
    n_chk++; if (upd_at !== c_last + 10) begin n_fail++; $display("FAIL hold_latency: got %0d want %0d", upd_at, c_last + 10); end
    n_chk++; if (n_upd !== 1) begin n_fail++; $display("FAIL hold_update_count: got %0d want 1", n_upd); end
    n_chk++; if (chg_early !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d early changes want 0", chg_early); end
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL hold_params: got %h want %h", outs, m_par); end
  endtask

  task automatic test_short_frame();
    send(32'($urandom), 10, 0);
    m_err = 1'b1;
    n_chk++; if (cfg_error !== 1'b1) begin n_fail++; $display("FAIL short_error: got %b want 1", cfg_error); end
    n_chk++; if (n_upd !== 0) begin n_fail++; $display("FAIL short_no_update: got %0d want 0", n_upd); end
    n_chk++; if (outs !== m_par || chg_early !== 0) begin n_fail++; $display("FAIL short_params: got %h want %h", outs, m_par); end
    n_chk++; if (params_ready !== m_ready) begin n_fail++; $display("FAIL short_ready: got %b want %b", params_ready, m_ready); end
  endtask

  task automatic test_extra_bits();
    logic [23:0] p;
    logic [31:0] f;
    p = 24'($urandom);
    f = mk_frame(p);
    f = (f << 3) | 32'd6;
    send(f, FB + 3, 0);
    m_par = p; m_ready = 1'b1; m_err = 1'b0;
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL extra_params: got %h want %h", outs, m_par); end
    n_chk++; if (n_upd !== 1 || upd_at !== c_last + 2) begin
      n_fail++; $display("FAIL extra_timing: got %0d updates at %0d want 1 at %0d", n_upd, upd_at, c_last + 2);
    end
    n_chk++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL extra_error: got %b want 0", cfg_error); end
  endtask

`ifdef ALIF_CFG_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [23:0] p;
    send(32'h4032150, 28, 0);
    m_err = 1'b1;
    n_chk++; if (cfg_error !== 1'b1) begin n_fail++; $display("FAIL badsum_error: got %b want 1", cfg_error); end
    n_chk++; if (n_upd !== 0) begin n_fail++; $display("FAIL badsum_no_update: got %0d want 0", n_upd); end
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL badsum_params: got %h want %h", outs, m_par); end
    n_chk++; if (params_ready !== m_ready) begin n_fail++; $display("FAIL badsum_ready: got %b want %b", params_ready, m_ready); end
    p = 24'($urandom);
    send(mk_frame(p), FB, 0);
    m_par = p; m_ready = 1'b1; m_err = 1'b0;
    n_chk++; if (cfg_error !== 1'b0 || n_upd !== 1) begin
      n_fail++; $display("FAIL badsum_recover: got err %b updates %0d want err 0 updates 1", cfg_error, n_upd);
    end
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL badsum_recover_params: got %h want %h", outs, m_par); end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [31:0] f;
    logic [23:0] p;
    send(32'($urandom), 7, 0);   // leaves cfg_error set
    f = mk_frame(24'($urandom));
    for (int i = FB - 1; i >= FB - 12; i--) begin
      @(posedge clk); #1;
      load_mode = 1'b1;
      serial_data = f[i];
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    m_par = DEF_PAR; m_ready = 1'b0; m_err = 1'b0;
    n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL midreset_params: got %h want %h", outs, m_par); end
    n_chk++; if (params_ready !== 1'b0 || cfg_error !== 1'b0 || cfg_update !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags: got ready %b err %b upd %b want 0 0 0", params_ready, cfg_error, cfg_update);
    end
    load_mode = 1'b0; serial_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send(32'($urandom), 5, 0);
    m_err = 1'b1;
    n_chk++; if (params_ready !== 1'b0 || cfg_error !== 1'b1) begin
      n_fail++; $display("FAIL midreset_short: got ready %b err %b want 0 1", params_ready, cfg_error);
    end
    p = 24'($urandom);
    send(mk_frame(p), FB, 0);
    m_par = p; m_ready = 1'b1; m_err = 1'b0;
    n_chk++; if (outs !== m_par || n_upd !== 1) begin
      n_fail++; $display("FAIL midreset_recommit: got %h (%0d updates) want %h (1)", outs, n_upd, m_par);
    end
    n_chk++; if (params_ready !== 1'b1 || cfg_error !== 1'b0) begin
      n_fail++; $display("FAIL midreset_recommit_flags: got ready %b err %b want 1 0", params_ready, cfg_error);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int kind, hold, nb;
      logic [23:0] p;
      logic [31:0] f;
      logic good;
      kind = $urandom_range(0, 3);
      hold = $urandom_range(0, 4);
      p = 24'($urandom);
      f = mk_frame(p);
      nb = FB;
      good = 1'b1;
      if (kind == 2) begin
        nb = $urandom_range(1, FB - 1);
        f = $urandom;
        good = 1'b0;
      end
`ifdef ALIF_CFG_CHECKSUM_EN
      if (kind == 3) begin
        f = f ^ 32'($urandom_range(1, 15));
        good = 1'b0;
      end
`endif
      send(f, nb, hold);
      if (good) begin
        m_par = p; m_ready = 1'b1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      n_chk++; if (n_upd !== (good ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_update_count: got %0d want %0d", it, n_upd, good ? 1 : 0); end
      if (good) begin
        n_chk++; if (upd_at !== c_last + 5 + hold) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, upd_at, c_last + 5 + hold); end
      end
      n_chk++; if (outs !== m_par) begin n_fail++; $display("FAIL rnd%0d_params: got %h want %h", it, outs, m_par); end
      n_chk++; if (params_ready !== m_ready) begin n_fail++; $display("FAIL rnd%0d_ready: got %b want %b", it, params_ready, m_ready); end
      n_chk++; if (cfg_error !== m_err) begin n_fail++; $display("FAIL rnd%0d_error: got %b want %b", it, cfg_error, m_err); end
      n_chk++; if (both_hi !== 0 || chg_early !== 0) begin
        n_fail++; $display("FAIL rnd%0d_exclusive: got overlap %0d early %0d want 0 0", it, both_hi, chg_early);
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_commit_hold();
    test_short_frame();
    test_extra_bits();
`ifdef ALIF_CFG_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
